// File: rtl/phy_cc_port_arbiter.sv
// phy_cc_port_arbiter: shares one BMC encoder/decoder across NUM_PORTS CC lines with a round-robin, idle-checked transmit arbiter
// clk, rst_n                   : clock, synchronous active-low reset
// pl2phy_reset_req, _reset_done: soft reset request (level) and completion pulse
// tx_req, tx_grant             : per-port transmit request and one-hot encoder grant
// tx_done, tx_result           : per-port completion pulse and result (1 sent, 0 line busy)
// enc_drive_en/_data, enc_done : shared encoder drive and end-of-packet pulse
// cc_in, cc_out, cc_oe         : per-port CC line sample, drive value and drive enable
// rx_port_sel, dec_in, dec_dis : receive port select, muxed decoder input, decoder disable
module phy_cc_port_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int TIME_SCALE_FLAG = 0,
   localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pl2phy_reset_req,
   output logic                 phy2pl_reset_done,
   input  logic [NUM_PORTS-1:0] tx_req,
   output logic [NUM_PORTS-1:0] tx_grant,
   output logic [NUM_PORTS-1:0] tx_done,
   output logic [NUM_PORTS-1:0] tx_result,
   input  logic                 enc_drive_en,
   input  logic                 enc_drive_data,
   input  logic                 enc_done,
   input  logic [NUM_PORTS-1:0] cc_in,
   output logic [NUM_PORTS-1:0] cc_out,
   output logic [NUM_PORTS-1:0] cc_oe,
   input  logic [SW-1:0]        rx_port_sel,
   output logic                 dec_in,
   output logic                 dec_dis
);
   localparam int IDLE_CYC = 48 << TIME_SCALE_FLAG;
   localparam int WW = $clog2(IDLE_CYC);
   typedef enum logic [2:0] {RST_HOLD, IDLE, CHECK, TX, DONE} state_t;
   state_t state;
   logic [NUM_PORTS-1:0] s1, s2, sel_oh;
   logic [SW-1:0] ptr, sel, pick, idx;
   logic [WW-1:0] wcnt;
   logic [1:0] ecnt, ecnt_nx, rcnt;
   logic edg;
   logic [2**SW-1:0] rx_vec;
   // reverse scan so the port closest after ptr wins
   always_comb begin
      pick = ptr;
      idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         idx = SW'((int'(ptr) + i) % NUM_PORTS);
         if (tx_req[idx]) pick = idx;
      end
   end
   // unused select codes read as an idle-high line
   always_comb begin
      rx_vec = '1;
      rx_vec[NUM_PORTS-1:0] = s2;
   end
   assign edg = s1[sel] ^ s2[sel];
   assign ecnt_nx = (ecnt == 2'd3 || !edg) ? ecnt : ecnt + 2'd1;
   assign sel_oh = NUM_PORTS'(1) << sel;
   assign tx_grant = (state == TX) ? sel_oh : '0;
   assign cc_oe = (state == TX && enc_drive_en) ? sel_oh : '0;
   assign cc_out = (state == TX && !enc_drive_data) ? sel_oh : '0;
   assign dec_in = rx_vec[rx_port_sel];
   assign dec_dis = !rst_n || state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '0;
         sel <= '0;
         wcnt <= '0;
         ecnt <= '0;
         rcnt <= '0;
         s1 <= '0;
         s2 <= '0;
         tx_done <= '0;
         tx_result <= '0;
         phy2pl_reset_done <= 1'b0;
      end else begin
         s1 <= cc_in;
         s2 <= s1;
         tx_done <= '0;
         tx_result <= '0;
         phy2pl_reset_done <= 1'b0;
         if (pl2phy_reset_req) begin
            state <= RST_HOLD;
            rcnt <= '0;
         end else begin
            case (state)
               RST_HOLD: begin
                  if (rcnt == 2'd2) begin
                     state <= IDLE;
                     phy2pl_reset_done <= 1'b1;
                  end else rcnt <= rcnt + 2'd1;
               end
               IDLE: begin
                  if (|tx_req) begin
                     state <= CHECK;
                     sel <= pick;
                     wcnt <= '0;
                     ecnt <= '0;
                  end
               end
               CHECK: begin
                  if (!tx_req[sel]) state <= IDLE;
                  else if (ecnt_nx == 2'd3) begin
                     state <= DONE;
                     tx_done <= sel_oh;
                  end else if (wcnt == WW'(IDLE_CYC - 1)) state <= TX;
                  else begin
                     wcnt <= wcnt + 1'b1;
                     ecnt <= ecnt_nx;
                  end
               end
               TX: begin
                  if (enc_done) begin
                     state <= DONE;
                     tx_done <= sel_oh;
                     tx_result <= sel_oh;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  ptr <= (sel == SW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
